// File: rtl/cfg_cpe_pkg.sv
// Shared types and constants for the multi-RAM config bridge.
// Token layout, status offsets and the miss response pattern.
package cfg_cpe_pkg;

    typedef enum logic [1:0] {
        KIND_RAM  = 2'd0,
        KIND_STAT = 2'd1,
        KIND_MISS = 2'd2
    } tok_kind_e;

    localparam logic [1:0] OFS_WR_CNT   = 2'd0;
    localparam logic [1:0] OFS_RD_CNT   = 2'd1;
    localparam logic [1:0] OFS_MISS_CNT = 2'd2;
    localparam logic [1:0] OFS_CTRL     = 2'd3;

    // Truncated to DATA_W at the point of use.
    localparam logic [63:0] MISS_DATA = '1;

    // Fields sized for the widest supported configuration.
    typedef struct packed {
        tok_kind_e   kind;
        logic [2:0]  bank;
        logic [31:0] addr;
        logic [31:0] snap;
    } tok_t;

endpackage

// File: rtl/cfg_rsp_delay_line.sv
// Fixed-depth valid/data shift pipeline.
// Every stage is cleared by the asynchronous reset.
module cfg_rsp_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] iv_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] ov_data
);

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] dat [DEPTH];

    // Shift valid and payload one stage per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld[i] <= 1'b0;
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= i_vld;
            dat[0] <= iv_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign o_vld   = vld[DEPTH-1];
    assign ov_data = dat[DEPTH-1];

endmodule

// File: rtl/cfg_multi_ram_bridge_cpe.sv
// Management-bus bridge onto NUM_BANK config RAMs plus
// access counters; reads answer as write pulses in order.
module cfg_multi_ram_bridge_cpe
    import cfg_cpe_pkg::*;
#(
    parameter int          ADDR_W    = 19,
    parameter int          DATA_W    = 32,
    parameter int          RAM_AW    = 10,
    parameter int          RAM_DW    = 16,
    parameter int          NUM_BANK  = 2,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          RD_LAT    = 3,
    parameter int          MISS_RESP = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_W-1:0]          iv_addr,
    input  logic                       i_addr_fixed,
    input  logic [DATA_W-1:0]          iv_wdata,
    input  logic                       i_wr,
    input  logic                       i_rd,
    output logic                       o_wr,
    output logic [ADDR_W-1:0]          ov_addr,
    output logic                       o_addr_fixed,
    output logic [DATA_W-1:0]          ov_rdata,
    output logic [RAM_AW-1:0]          ov_ram_addr,
    output logic [RAM_DW-1:0]          ov_ram_wdata,
    output logic [NUM_BANK-1:0]        ov_ram_wr,
    output logic [NUM_BANK-1:0]        ov_ram_rd,
    input  logic [NUM_BANK*RAM_DW-1:0] iv_ram_rdata
);

    localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int TOK_W  = $bits(tok_t);
    localparam logic [ADDR_W-1:0] SPAN =
        ADDR_W'(NUM_BANK << RAM_AW);
    localparam logic [ADDR_W:0] BASE_X =
        (ADDR_W+1)'(BASE_ADDR);

    logic [ADDR_W:0]   off_x;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] soff;
    logic              above;
    logic              in_ram;
    logic              in_stat;
    logic              mapped;
    logic [1:0]        sidx;
    logic [BANK_W-1:0] bank;
    logic [NUM_BANK-1:0] bank_oh;

    // The extra top bit of off_x flags addresses below the base.
    assign off_x   = {1'b0, iv_addr} - BASE_X;
    assign above   = ~off_x[ADDR_W];
    assign off     = off_x[ADDR_W-1:0];
    assign soff    = off - SPAN;
    assign in_ram  = above && (off < SPAN);
    assign in_stat = above && !in_ram && (soff < ADDR_W'(4));
    assign mapped  = in_ram || in_stat;
    assign sidx    = soff[1:0];
    assign bank    = off[RAM_AW +: BANK_W];
    assign bank_oh = NUM_BANK'(1) << bank;

    logic       wr_req;
    logic       rd_req;
    logic       rd_drop;
    logic       clr;
    logic [1:0] miss_add;

    // A write beats a same-cycle read; the lost read counts as a miss.
    assign wr_req  = i_addr_fixed & i_wr;
    assign rd_req  = i_addr_fixed & i_rd & ~i_wr;
    assign rd_drop = i_addr_fixed & i_wr & i_rd;
    assign clr     = wr_req & in_stat & (sidx == OFS_CTRL)
                   & iv_wdata[0];
    assign miss_add = {1'b0, (wr_req | rd_req) & ~mapped}
                    + {1'b0, rd_drop};

    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] snap;

    // Status value as seen in the request cycle.
    always_comb begin
        snap = '0;
        case (sidx)
            OFS_WR_CNT:   snap = wr_cnt;
            OFS_RD_CNT:   snap = rd_cnt;
            OFS_MISS_CNT: snap = miss_cnt;
            default:      snap = '0;
        endcase
    end

    tok_t tok_in;
    tok_t tok_out;
    logic tok_vld;
    logic tok_out_vld;
    logic [TOK_W-1:0] tok_out_bits;

    // Build the response token for a read.
    always_comb begin
        tok_in      = '0;
        tok_in.bank = 3'(bank);
        tok_in.addr = 32'(iv_addr);
        tok_in.snap = snap;
        if (in_ram)       tok_in.kind = KIND_RAM;
        else if (in_stat) tok_in.kind = KIND_STAT;
        else              tok_in.kind = KIND_MISS;
    end

    assign tok_vld = rd_req & (mapped | (MISS_RESP != 0));

    cfg_rsp_delay_line #(
        .DEPTH (RD_LAT + 1),
        .WIDTH (TOK_W)
    ) u_tok_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_vld   (tok_vld),
        .iv_data (tok_in),
        .o_vld   (tok_out_vld),
        .ov_data (tok_out_bits)
    );

    assign tok_out = tok_out_bits;

    logic [RAM_DW-1:0] ram_sel;
    logic [DATA_W-1:0] rsp_data;

    // Pick the bank lane named by the emerging token.
    always_comb begin
        ram_sel = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (tok_out.bank == 3'(b))
                ram_sel = iv_ram_rdata[b*RAM_DW +: RAM_DW];
        end
    end

    // Response payload by token kind.
    always_comb begin
        rsp_data = '0;
        unique case (tok_out.kind)
            KIND_RAM:  rsp_data = DATA_W'(ram_sel);
            KIND_STAT: rsp_data = DATA_W'(tok_out.snap);
            default:   rsp_data = DATA_W'(MISS_DATA);
        endcase
    end

    // RAM strobe stage; idle cycles drive address and data to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_ram_wr    <= '0;
            ov_ram_rd    <= '0;
            ov_ram_addr  <= '0;
            ov_ram_wdata <= '0;
        end else begin
            ov_ram_wr    <= (wr_req & in_ram) ? bank_oh : '0;
            ov_ram_rd    <= (rd_req & in_ram) ? bank_oh : '0;
            ov_ram_addr  <= ((wr_req | rd_req) & in_ram)
                          ? off[RAM_AW-1:0] : '0;
            ov_ram_wdata <= (wr_req & in_ram)
                          ? iv_wdata[RAM_DW-1:0] : '0;
        end
    end

    // Wrapping counters; clear overrides any same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            miss_cnt <= '0;
        end else if (clr) begin
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            wr_cnt   <= wr_cnt + 32'(wr_req & mapped);
            rd_cnt   <= rd_cnt + 32'(rd_req & mapped);
            miss_cnt <= miss_cnt + 32'(miss_add);
        end
    end

    // Registered response; all fields are 0 between pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr         <= 1'b0;
            o_addr_fixed <= 1'b0;
            ov_addr      <= '0;
            ov_rdata     <= '0;
        end else begin
            o_wr         <= tok_out_vld;
            o_addr_fixed <= tok_out_vld;
            ov_addr      <= tok_out_vld
                          ? ADDR_W'(tok_out.addr) : '0;
            ov_rdata     <= tok_out_vld ? rsp_data : '0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{iv_wdata, tok_out.addr, tok_out.snap};

endmodule

// File: tb/tb_cfg_multi_ram_bridge_cpe.sv
// Randomised bench for cfg_multi_ram_bridge_cpe with a
// request-level reference model and an emulated bank RAM.
module tb_cfg_multi_ram_bridge_cpe;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 32;
    localparam int RAM_AW   = 10;
    localparam int RAM_DW   = 16;
    localparam int NUM_BANK = 2;
    localparam int RD_LAT   = 3;
    localparam int S        = NUM_BANK << RAM_AW;
    localparam int DEPTH    = 1 << RAM_AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] addr;
    logic              fx;
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              rd;
    logic [NUM_BANK*RAM_DW-1:0] ram_rdata;

    logic              o_wr1, o_af1, o_wr0, o_af0;
    logic [ADDR_W-1:0] ov_addr1, ov_addr0;
    logic [DATA_W-1:0] ov_rdata1, ov_rdata0;
    logic [RAM_AW-1:0] ram_addr1, ram_addr0;
    logic [RAM_DW-1:0] ram_wdata1, ram_wdata0;
    logic [NUM_BANK-1:0] ram_wr1, ram_rd1, ram_wr0, ram_rd0;

    cfg_multi_ram_bridge_cpe #(.MISS_RESP(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .iv_addr(addr),
        .i_addr_fixed(fx), .iv_wdata(wdata), .i_wr(wr), .i_rd(rd),
        .o_wr(o_wr1), .ov_addr(ov_addr1), .o_addr_fixed(o_af1),
        .ov_rdata(ov_rdata1), .ov_ram_addr(ram_addr1),
        .ov_ram_wdata(ram_wdata1), .ov_ram_wr(ram_wr1),
        .ov_ram_rd(ram_rd1), .iv_ram_rdata(ram_rdata)
    );

    cfg_multi_ram_bridge_cpe #(.MISS_RESP(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .iv_addr(addr),
        .i_addr_fixed(fx), .iv_wdata(wdata), .i_wr(wr), .i_rd(rd),
        .o_wr(o_wr0), .ov_addr(ov_addr0), .o_addr_fixed(o_af0),
        .ov_rdata(ov_rdata0), .ov_ram_addr(ram_addr0),
        .ov_ram_wdata(ram_wdata0), .ov_ram_wr(ram_wr0),
        .ov_ram_rd(ram_rd0), .iv_ram_rdata(ram_rdata)
    );

    // Bank RAMs driven by dut1 strobes; idle lanes carry noise.
    logic [RAM_DW-1:0] emu [NUM_BANK][DEPTH];
    logic [NUM_BANK*RAM_DW-1:0] pipe [RD_LAT];
    logic [NUM_BANK*RAM_DW-1:0] nv;

    always @(posedge clk) begin
        nv = $urandom;
        for (int b = 0; b < NUM_BANK; b++)
            if (ram_rd1[b]) nv[b*RAM_DW +: RAM_DW] = emu[b][ram_addr1];
        for (int b = 0; b < NUM_BANK; b++)
            if (ram_wr1[b]) emu[b][ram_addr1] <= ram_wdata1;
        pipe[0] <= nv;
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign ram_rdata = pipe[RD_LAT-1];

    typedef struct {
        int          due;
        logic [52:0] v;
    } rsp_t;

    logic [RAM_DW-1:0] ref_mem [NUM_BANK][DEPTH];
    logic [31:0] m_wr, m_rd, m_miss;
    logic [29:0] exp_iss;
    rsp_t q1[$], q0[$];
    int cyc;
    int errs;
    int checks;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // Reference: effect of one bus request, from the address map rules.
    task automatic model(input logic f, input logic w, input logic r,
                         input logic [ADDR_W-1:0] a,
                         input logic [31:0] d);
        int off, b, ra;
        bit in_ram, in_st, mp, clr;
        logic [31:0] snap, rdat;
        rsp_t t;
        exp_iss = '0;
        if (!f) return;
        off    = int'(a);
        in_ram = off < S;
        in_st  = (off >= S) && (off < S + 4);
        mp     = in_ram || in_st;
        b      = off / DEPTH;
        ra     = off % DEPTH;
        clr    = 0;
        if (off == S)          snap = m_wr;
        else if (off == S + 1) snap = m_rd;
        else if (off == S + 2) snap = m_miss;
        else                   snap = 32'h0;
        if (w) begin
            if (in_ram) begin
                ref_mem[b][ra] = d[15:0];
                exp_iss = {2'(1 << b), 2'b00, 10'(ra), d[15:0]};
            end
            if (mp) m_wr++; else m_miss++;
            if (off == S + 3 && d[0]) clr = 1;
            if (r) m_miss++;
        end else if (r) begin
            if (in_ram) exp_iss = {2'b00, 2'(1 << b), 10'(ra), 16'h0};
            rdat = in_ram ? {16'h0, ref_mem[b][ra]}
                 : in_st  ? snap : 32'hFFFF_FFFF;
            t.due = cyc + RD_LAT + 2;
            t.v   = {1'b1, 1'b1, a, rdat};
            q1.push_back(t);
            if (mp) q0.push_back(t);
            if (mp) m_rd++; else m_miss++;
        end
        if (clr) begin
            m_wr = 0; m_rd = 0; m_miss = 0;
        end
    endtask

    task automatic check_cycle();
        logic [52:0] e1, e0;
        rsp_t t;
        e1 = '0;
        e0 = '0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            t = q1.pop_front(); e1 = t.v;
        end
        if (q0.size() > 0 && q0[0].due == cyc) begin
            t = q0.pop_front(); e0 = t.v;
        end
        chk("issue", {ram_wr1, ram_rd1, ram_addr1, ram_wdata1}, exp_iss);
        chk("rsp_miss1", {o_wr1, o_af1, ov_addr1, ov_rdata1}, e1);
        chk("rsp_miss0", {o_wr0, o_af0, ov_addr0, ov_rdata0}, e0);
    endtask

    task automatic step(input logic f, input logic w, input logic r,
                        input logic [ADDR_W-1:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        fx = f; wr = w; rd = r; addr = a; wdata = d;
        model(f, w, r, a, d);
        @(posedge clk);
        cyc++;
        #1 check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_iss"},
            {ram_wr1, ram_rd1, ram_addr1, ram_wdata1}, 64'h0);
        chk({tag, "_rsp1"}, {o_wr1, o_af1, ov_addr1, ov_rdata1}, 64'h0);
        chk({tag, "_rsp0"}, {o_wr0, o_af0, ov_addr0, ov_rdata0}, 64'h0);
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        logic w, r;
        int k, sel;
        errs = 0; checks = 0; cyc = 0;
        m_wr = 0; m_rd = 0; m_miss = 0; exp_iss = '0;
        fx = 0; wr = 0; rd = 0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        #12 chk_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        step(1, 1, 0, 19'd5, 32'h0000_ABCD);
        step(1, 0, 1, 19'(S), 32'h0);
        step(1, 1, 0, 19'd1031, 32'h0000_1234);
        idle(1);
        step(1, 0, 1, 19'd1031, 32'h0);
        idle(RD_LAT + 3);

        for (int i = 0; i < 8; i++)
            step(1, 0, 1, 19'($urandom_range(0, S - 1)), 32'h0);
        step(1, 0, 1, 19'(S + 1), 32'h0);
        idle(RD_LAT + 3);

        step(1, 0, 1, 19'd3000, 32'h0);
        step(1, 0, 1, 19'(S + 2), 32'h0);
        idle(RD_LAT + 3);

        step(1, 1, 1, 19'd2, 32'h0000_5A5A);
        step(1, 0, 1, 19'(S + 2), 32'h0);
        step(1, 1, 1, 19'(S + 3), 32'h0000_0001);
        step(1, 0, 1, 19'(S), 32'h0);
        step(1, 0, 1, 19'(S + 1), 32'h0);
        step(1, 0, 1, 19'(S + 2), 32'h0);
        step(1, 0, 1, 19'(S + 3), 32'h0);
        step(0, 0, 1, 19'd7, 32'h0);
        step(0, 1, 0, 19'd7, 32'hFFFF);
        idle(RD_LAT + 3);

        step(1, 0, 1, 19'd10, 32'h0);
        step(1, 0, 1, 19'd1100, 32'h0);
        step(1, 0, 1, 19'(S), 32'h0);
        #2;
        fx = 0; wr = 0; rd = 0; addr = '0; wdata = '0;
        rst_n = 1'b0;
        #1 chk_all_zero("midrst");
        q1.delete(); q0.delete();
        m_wr = 0; m_rd = 0; m_miss = 0; exp_iss = '0;
        repeat (2) begin
            @(posedge clk); cyc++;
        end
        @(negedge clk) rst_n = 1'b1;
        idle(10);

        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      a = 19'($urandom_range(0, S - 1));
            else if (sel < 85) a = 19'(S + $urandom_range(0, 3));
            else               a = 19'($urandom_range(S + 4, (1 << ADDR_W) - 1));
            k = $urandom_range(0, 9);
            w = (k <= 2) || (k == 9 && sel < 85);
            r = (k >= 3 && k <= 7) || k == 9;
            step(($urandom_range(0, 9) != 0), w, r, a, $urandom);
        end
        step(1, 0, 1, 19'(S), 32'h0);
        step(1, 0, 1, 19'(S + 1), 32'h0);
        step(1, 0, 1, 19'(S + 2), 32'h0);
        idle(RD_LAT + 4);
        chk("drain1", 64'(q1.size()), 64'h0);
        chk("drain0", 64'(q0.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/cfg_multi_ram_bridge_cpe.md
Name: cfg_multi_ram_bridge_cpe

Overview:
- Configuration-path element that bridges the local management bus (address, addr_fixed, wdata, wr, rd) to NUM_BANK single-port config RAMs.
- Also holds a small set of access-statistics registers.
- Read responses return on the same bus format as a write pulse carrying the full requester address.
- Successor to the single-RAM fixed-latency CPE: banks, RAM widths, base address and RAM read latency are parametrised; unmapped-access handling and counters are new.

Parameters:
ADDR_W, 19, management address width
DATA_W, 32, management data width
RAM_AW, 10, per-bank RAM address width
RAM_DW, 16, per-bank RAM data width (RAM_DW <= DATA_W)
NUM_BANK, 2, number of RAM banks (1..8)
BASE_ADDR, 0, first management address owned by this block
RD_LAT, 3, RAM read latency: cycles from strobe edge to valid iv_ram_rdata (>=1)
MISS_RESP, 1, 1 = unmapped reads return an error response; 0 = unmapped reads are silent

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
iv_addr  in  ADDR_W  request address
i_addr_fixed  in  1  request targets the local fixed address space
iv_wdata  in  DATA_W  write data
i_wr  in  1  write strobe, one cycle
i_rd  in  1  read strobe, one cycle
o_wr  out  1  response valid pulse
ov_addr  out  ADDR_W  response address (original request address)
o_addr_fixed  out  1  response addr_fixed, 1 with o_wr
ov_rdata  out  DATA_W  response data
ov_ram_addr  out  RAM_AW  shared RAM address
ov_ram_wdata  out  RAM_DW  shared RAM write data
ov_ram_wr  out  NUM_BANK  per-bank write enable
ov_ram_rd  out  NUM_BANK  per-bank read enable
iv_ram_rdata  in  NUM_BANK*RAM_DW  concatenated bank read data, bank0 in LSBs

Behaviour:
- Reset: every output is 0; counters are 0; response pipeline is empty.
- Requests with i_addr_fixed=0 are ignored entirely: no strobe, no response, no counting.
- Decode: off = iv_addr - BASE_ADDR, evaluated only when iv_addr >= BASE_ADDR.
  - RAM region: off < NUM_BANK<<RAM_AW; bank = off[RAM_AW +: clog2(NUM_BANK)]; RAM addr = off[RAM_AW-1:0].
  - Status region: off = S+0..S+3, where S = NUM_BANK<<RAM_AW.
    - S+0 WR_CNT (RO)
    - S+1 RD_CNT (RO)
    - S+2 MISS_CNT (RO)
    - S+3 CTRL: bit0 clear, write-1, self-clearing, reads 0.
  - Anything else, including iv_addr < BASE_ADDR: unmapped.
- Issue stage (registered, cycle T+1 for a request at T):
  - RAM write: ov_ram_wr[bank]=1; ov_ram_addr and ov_ram_wdata = iv_wdata[RAM_DW-1:0].
  - RAM read: ov_ram_rd[bank]=1; ov_ram_addr set; ov_ram_wdata=0.
  - Idle: all strobes 0; ov_ram_addr and ov_ram_wdata = 0.
- Simultaneous i_wr and i_rd: the write is performed and the read is dropped. MISS_CNT increments by 1.
- Counters: 32-bit, wrapping.
  - WR_CNT increments on every mapped write (RAM or status).
  - RD_CNT increments on every mapped read.
  - MISS_CNT increments on every unmapped access and on every dropped read.
  - A clear write takes effect at T+1 and wins over any same-cycle increment.
  - Writes to RO status registers count as writes and are otherwise discarded.
- Response pipeline:
  - Each read launches a token {kind (RAM/STAT/MISS), bank, full address, status snapshot} at T+1.
  - The token is delayed RD_LAT cycles.
  - At T+1+RD_LAT the selected bank data is sampled and zero-extended to DATA_W. STAT tokens use the snapshot captured at T. MISS tokens use all-ones.
  - Output is registered: o_wr=1, o_addr_fixed=1, ov_addr = original iv_addr, at cycle T+RD_LAT+2. All response outputs are 0 otherwise.
  - MISS tokens are dropped when MISS_RESP=0.
- Throughput: one read per cycle sustained. Responses stay in request order, with no bubbles inserted.
- Reset mid-operation clears all in-flight tokens; no response is issued after reset deassertion.

Decomposition:
- Package cfg_cpe_pkg holds:
  - token kind enum (KIND_RAM, KIND_STAT, KIND_MISS)
  - status offsets (OFS_WR_CNT=0, OFS_RD_CNT=1, OFS_MISS_CNT=2, OFS_CTRL=3)
  - MISS_DATA = all-ones constant
  - token struct
- Sub-module cfg_rsp_delay_line: parametrised DEPTH x WIDTH valid/data shift pipeline with asynchronous reset. It is instantiated once for the token path.

Test Plan:
- Defaults, write 0x0000ABCD to addr 5 -> ov_ram_wr=2'b01, ov_ram_addr=5, ov_ram_wdata=0xABCD at T+1; WR_CNT=1.
- Read addr 1024+7 (bank1), iv_ram_rdata[31:16]=0x1234 at T+4 -> o_wr at T+5, ov_addr=1031, ov_rdata=0x00001234; no response at any other cycle.
- 8 back-to-back reads across both banks -> 8 consecutive o_wr pulses in request order, each returning its own address; RD_CNT=8.
- Read addr 3000 (unmapped), MISS_RESP=1 -> o_wr at T+5 with ov_rdata=0xFFFFFFFF, MISS_CNT=1. Repeat with MISS_RESP=0 -> no o_wr, MISS_CNT=1.
- i_wr and i_rd together to addr 2 -> only ov_ram_wr asserted, no response, MISS_CNT+1. Then write 1 to CTRL (addr 2051) with a concurrent increment -> all counters read back 0.
- Issue 3 reads, assert i_rst_n=0 at T+2 -> all outputs 0 immediately; after release, no o_wr for 10 cycles. Also: i_addr_fixed=0 read -> nothing happens.
